// File: rtl/parking_slot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : parking_slot_ctrl_if
// Brief    : Sensor request / gate-and-count status bundle for parking_slot_ctrl
// Revision : 1.0
// ============================================================================
interface parking_slot_ctrl_if;
    logic       entry_req;
    logic       exit_req;
    logic       gate_open;
    logic [3:0] free_slots;
    logic       count_valid;
    logic       full;
    logic       reject;

    modport master (
        output entry_req,
        output exit_req,
        input  gate_open,
        input  free_slots,
        input  count_valid,
        input  full,
        input  reject
    );

    modport slave (
        input  entry_req,
        input  exit_req,
        output gate_open,
        output free_slots,
        output count_valid,
        output full,
        output reject
    );
endinterface
`default_nettype wire

// File: rtl/parking_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parking_slot_ctrl
// Brief    : Entry/exit barrier sequencer with timed gate window and free-slot count
// Revision : 1.0
// ============================================================================
module parking_slot_ctrl #(
    parameter int CAPACITY    = 12,
    parameter int GATE_CYCLES = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    parking_slot_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        LEAVE = 2'd2
    } state_t;

    localparam logic [3:0] c_capacity  = 4'(CAPACITY);
    localparam logic [7:0] c_gate_load = 8'(GATE_CYCLES - 1);

    state_t     state_q,       state_d;
    logic [7:0] timer_q,       timer_d;
    logic [3:0] free_q,        free_d;
    logic       pend_in_q,     pend_in_d;
    logic       pend_out_q,    pend_out_d;
    logic       reject_q,      reject_d;
    logic       gate_open_q,   gate_open_d;
    logic       count_valid_q, count_valid_d;
    logic       entry_q;
    logic       exit_q;

    logic       w_entry_edge;
    logic       w_exit_edge;
    logic       w_entry_src;
    logic       w_exit_src;

    assign w_entry_edge = bus.entry_req & ~entry_q;
    assign w_exit_edge  = bus.exit_req  & ~exit_q;
    assign w_entry_src  = w_entry_edge | pend_in_q;
    assign w_exit_src   = w_exit_edge  | pend_out_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        free_d     = free_q;
        // Edges arriving in any state latch into a depth-1 pending flag
        pend_in_d  = pend_in_q  | w_entry_edge;
        pend_out_d = pend_out_q | w_exit_edge;
        reject_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Departures win so a full lot can always drain
                if (w_exit_src) begin
                    pend_out_d = 1'b0;
                    if (free_q < c_capacity) begin
                        state_d = LEAVE;
                        timer_d = c_gate_load;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (w_entry_src) begin
                    pend_in_d = 1'b0;
                    if (free_q != 4'd0) begin
                        state_d = ENTER;
                        timer_d = c_gate_load;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ENTER: begin
                if (timer_q == 8'd0) begin
                    state_d = IDLE;
                    free_d  = free_q - 4'd1;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            LEAVE: begin
                if (timer_q == 8'd0) begin
                    state_d = IDLE;
                    free_d  = free_q + 4'd1;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gate_open_d   = (state_d != IDLE);
        count_valid_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        // Sensor history tracks the inputs even in reset so a held level is not an edge
        entry_q <= bus.entry_req;
        exit_q  <= bus.exit_req;
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= 8'd0;
            free_q        <= c_capacity;
            pend_in_q     <= 1'b0;
            pend_out_q    <= 1'b0;
            reject_q      <= 1'b0;
            gate_open_q   <= 1'b0;
            count_valid_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            free_q        <= free_d;
            pend_in_q     <= pend_in_d;
            pend_out_q    <= pend_out_d;
            reject_q      <= reject_d;
            gate_open_q   <= gate_open_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign bus.gate_open   = gate_open_q;
    assign bus.count_valid = count_valid_q;
    assign bus.free_slots  = free_q;
    assign bus.full        = (free_q == 4'd0);
    assign bus.reject      = reject_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_slot_ctrl
// Brief    : Directed self-checking bench for parking_slot_ctrl (CAPACITY=12, GATE_CYCLES=8)
// Revision : 1.0
// ============================================================================
module tb_parking_slot_ctrl;

    localparam int CAP  = 12;
    localparam int GATE = 8;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    parking_slot_ctrl_if bus ();

    parking_slot_ctrl #(
        .CAPACITY    (CAP),
        .GATE_CYCLES (GATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] exp_free);
        chk({tag, ".gate"},  {7'd0, bus.gate_open},   8'd0);
        chk({tag, ".cv"},    {7'd0, bus.count_valid}, 8'd1);
        chk({tag, ".free"},  {4'd0, bus.free_slots},  {4'd0, exp_free});
        chk({tag, ".full"},  {7'd0, bus.full},        {7'd0, (exp_free == 4'd0)});
    endtask

    // Current sample is the first open-gate cycle; walks the window then the idle cycle.
    task automatic window(input string tag, input logic [3:0] exp_free);
        int open_cnt;
        open_cnt = 0;
        for (int k = 1; k <= GATE; k++) begin
            if (k > 1) step();
            if (bus.gate_open === 1'b1 && bus.count_valid === 1'b0) open_cnt++;
        end
        chk({tag, ".open_cycles"}, 8'(open_cnt), 8'(GATE));
        step();
        chk_idle({tag, ".done"}, exp_free);
    endtask

    task automatic do_entry(input string tag, input logic [3:0] exp_free);
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        window(tag, exp_free);
    endtask

    task automatic do_exit(input string tag, input logic [3:0] exp_free);
        bus.exit_req = 1'b1;
        step();
        bus.exit_req = 1'b0;
        window(tag, exp_free);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk_idle("reset", 4'd12);
        chk("reset.reject", {7'd0, bus.reject}, 8'd0);

        // Exit with an empty lot is refused
        bus.exit_req = 1'b1;
        step();
        bus.exit_req = 1'b0;
        chk("exit_rej.reject", {7'd0, bus.reject}, 8'd1);
        chk_idle("exit_rej", 4'd12);
        step();
        chk("exit_rej.reject_end", {7'd0, bus.reject}, 8'd0);
        chk_idle("exit_rej.after", 4'd12);

        // First entry with explicit window edges
        step();
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        chk("entry1.gate_first", {7'd0, bus.gate_open},   8'd1);
        chk("entry1.cv_first",   {7'd0, bus.count_valid}, 8'd0);
        chk("entry1.free_hold",  {4'd0, bus.free_slots},  8'd12);
        window("entry1", 4'd11);

        // Fill the lot
        for (int n = 2; n <= CAP; n++) begin
            do_entry($sformatf("fill%0d", n), 4'(CAP - n));
        end

        // Thirteenth entry refused
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        chk("entry_rej.reject", {7'd0, bus.reject}, 8'd1);
        chk_idle("entry_rej", 4'd0);
        step();
        chk("entry_rej.reject_end", {7'd0, bus.reject}, 8'd0);
        chk_idle("entry_rej.after", 4'd0);

        // Drain to five free slots
        for (int n = 1; n <= 5; n++) begin
            do_exit($sformatf("drain%0d", n), 4'(n));
        end

        // Simultaneous edges: LEAVE first, one idle cycle, then ENTER
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        step();
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        window("both.leave", 4'd6);
        step();
        chk("both.enter_gate", {7'd0, bus.gate_open}, 8'd1);
        window("both.enter", 4'd5);

        // Two more entry edges inside an active ENTER window merge into one
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        for (int k = 1; k <= GATE; k++) begin
            if (k > 1) step();
            chk($sformatf("merge.gate%0d", k), {7'd0, bus.gate_open}, 8'd1);
            bus.entry_req = (k == 3 || k == 5);
        end
        bus.entry_req = 1'b0;
        step();
        chk_idle("merge.gap", 4'd4);
        step();
        chk("merge.second_gate", {7'd0, bus.gate_open}, 8'd1);
        window("merge.second", 4'd3);
        step();
        chk_idle("merge.no_third", 4'd3);
        step();
        chk_idle("merge.no_third2", 4'd3);

        // Reset in the 4th window cycle with entry held high
        bus.entry_req = 1'b1;
        step();
        step();
        step();
        step();
        chk("rst_mid.gate_before", {7'd0, bus.gate_open}, 8'd1);
        rst = 1'b1;
        step();
        chk_idle("rst_mid.reset", 4'd12);
        chk("rst_mid.reject", {7'd0, bus.reject}, 8'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle($sformatf("rst_mid.after%0d", k), 4'd12);
        end
        bus.entry_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
